// File: rtl/arc4_pkg.sv
// arc4_pkg: shared ARC4 types and constants for init, ksa, prga and the arc4 top
package arc4_pkg;

    localparam int MEM_DEPTH       = 256;
    localparam int LEN_ADDR        = 0;
    localparam int CYCLES_PER_BYTE = 6;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WR_PT,
        DONE
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// prga: RC4 keystream generation, XORs the length-prefixed ciphertext into plaintext
module prga
    import arc4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    prga_state_t       r_state, w_next;
    logic              r_rdy;
    logic [ADDR_W-1:0] r_i, r_j;
    logic [ADDR_W:0]   r_k;
    logic [DATA_W-1:0] r_len, r_si, r_sj, r_ctk;
    logic              w_s_wren, w_pt_wren;

    assign rdy     = r_rdy;
    // Write enables drop the moment reset is asserted so an aborted run never commits another write
    assign s_wren  = w_s_wren & rst_n;
    assign pt_wren = w_pt_wren & rst_n;

    // Next state and memory port drive, decoded from the current step
    always_comb begin
        w_next    = r_state;
        s_addr    = '0;
        s_wrdata  = '0;
        w_s_wren  = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        w_pt_wren = 1'b0;
        case (r_state)
            IDLE: w_next = (r_rdy && en) ? RD_LEN : IDLE;
            RD_LEN: begin
                ct_addr = ADDR_W'(LEN_ADDR);
                w_next  = WR_LEN;
            end
            WR_LEN: begin
                pt_addr   = ADDR_W'(LEN_ADDR);
                pt_wrdata = ct_rddata;
                w_pt_wren = 1'b1;
                w_next    = (ct_rddata == '0) ? DONE : RD_SI;
            end
            RD_SI: begin
                s_addr = r_i + 1'b1;
                w_next = RD_SJ;
            end
            RD_SJ: begin
                s_addr  = r_j + s_rddata;
                ct_addr = r_k[ADDR_W-1:0];
                w_next  = WR_SI;
            end
            WR_SI: begin
                s_addr   = r_i;
                s_wrdata = s_rddata;
                w_s_wren = 1'b1;
                w_next   = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = r_j;
                s_wrdata = r_si;
                w_s_wren = 1'b1;
                w_next   = RD_PAD;
            end
            RD_PAD: begin
                s_addr = r_si + r_sj;
                w_next = WR_PT;
            end
            WR_PT: begin
                pt_addr   = r_k[ADDR_W-1:0];
                pt_wrdata = s_rddata ^ r_ctk;
                w_pt_wren = 1'b1;
                w_next    = (r_k >= {1'b0, r_len}) ? DONE : RD_SI;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, handshake and index/datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_len   <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_ctk   <= '0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next == IDLE);
            case (r_state)
                WR_LEN: begin
                    r_len <= ct_rddata;
                    r_i   <= '0;
                    r_j   <= '0;
                    r_k   <= 1;
                end
                RD_SI: r_i <= r_i + 1'b1;
                RD_SJ: begin
                    r_si <= s_rddata;
                    r_j  <= r_j + s_rddata;
                end
                WR_SI: begin
                    r_sj  <= s_rddata;
                    r_ctk <= ct_rddata;
                end
                WR_PT:   r_k <= r_k + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prga.sv
// tb_prga: directed self-checking bench for the RC4 PRGA stage
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] gs [256];
    logic [7:0] gct [256];
    logic [7:0] gpt [256];

    int cyc = 0;
    int s_wr_cnt = 0;
    int pt_wr_cnt = 0;
    int both_cnt = 0;
    int checks = 0;
    int errors = 0;

    prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren && pt_wren) both_cnt = both_cnt + 1;
        if (s_wren) begin
            s_mem[s_addr] = s_wrdata;
            s_wr_cnt = s_wr_cnt + 1;
        end
        if (pt_wren) begin
            pt_mem[pt_addr] = pt_wrdata;
            pt_wr_cnt = pt_wr_cnt + 1;
        end
    end

    task automatic load_identity();
        for (int n = 0; n < 256; n++) begin
            s_mem[n] = 8'(n);
            gs[n] = 8'(n);
            pt_mem[n] = 8'hEE;
        end
    endtask

    task automatic model_prga(input int len);
        int i, j;
        logic [7:0] t;
        i = 0;
        j = 0;
        gpt[0] = 8'(len);
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(gs[i])) % 256;
            t = gs[i];
            gs[i] = gs[j];
            gs[j] = t;
            gpt[k] = gct[k] ^ gs[8'(gs[i] + gs[j])];
        end
    endtask

    task automatic run(input int pulse_at, output int dur);
        int t0;
        dur = -1;
        en = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                dur = cyc - t0;
                break;
            end
            en = (n == pulse_at);
        end
        en = 1'b0;
        checks++;
        if (dur < 0) begin
            errors++;
            $display("FAIL run_timeout: rdy never returned within 3000 cycles, required a return");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdy, s_wren, pt_wren} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/s_wren/pt_wren=%b required 000", {rdy, s_wren, pt_wren});
        end
        checks++;
        if ({s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata} !== 40'h0) begin
            errors++;
            $display("FAIL reset_bus: addr/data=%h required 0", {s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b required 1", rdy);
        end
    endtask

    task automatic test_identity();
        int dur, bad;
        logic [7:0] exp_s [256];
        logic [7:0] exp_pt [4];
        load_identity();
        ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
        exp_pt[0] = 8'h03; exp_pt[1] = 8'h43; exp_pt[2] = 8'h47; exp_pt[3] = 8'h44;
        run(4, dur);
        checks++;
        if (dur !== 21) begin
            errors++;
            $display("FAIL identity_cycles: got %0d required 21", dur);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pt_mem[n] !== exp_pt[n]) begin
                errors++;
                $display("FAIL identity_pt[%0d]: got %h required %h", n, pt_mem[n], exp_pt[n]);
            end
        end
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        exp_s[2] = 8'h03; exp_s[3] = 8'h05; exp_s[5] = 8'h02;
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL identity_s: %0d entries differ (s2=%h s3=%h s5=%h) required 03 05 02 others unchanged", bad, s_mem[2], s_mem[3], s_mem[5]);
        end
    endtask

    task automatic test_len0();
        int dur, w0;
        load_identity();
        ct_mem[0] = 8'h00;
        w0 = pt_wr_cnt;
        run(-1, dur);
        checks++;
        if (dur !== 3) begin
            errors++;
            $display("FAIL len0_cycles: got %0d required 3", dur);
        end
        checks++;
        if (pt_wr_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL len0_writes: got %0d required 1", pt_wr_cnt - w0);
        end
        checks++;
        if (pt_mem[0] !== 8'h00 || pt_mem[1] !== 8'hEE) begin
            errors++;
            $display("FAIL len0_pt: pt0=%h pt1=%h required 00 EE", pt_mem[0], pt_mem[1]);
        end
    endtask

    task automatic test_len255();
        int dur, w0, bad, r;
        logic [7:0] t;
        load_identity();
        for (int n = 255; n > 0; n--) begin
            r = int'($urandom_range(n, 0));
            t = s_mem[n]; s_mem[n] = s_mem[r]; s_mem[r] = t;
        end
        for (int n = 0; n < 256; n++) gs[n] = s_mem[n];
        ct_mem[0] = 8'hFF;
        gct[0] = 8'hFF;
        for (int n = 1; n < 256; n++) begin
            ct_mem[n] = 8'($urandom);
            gct[n] = ct_mem[n];
        end
        model_prga(255);
        w0 = pt_wr_cnt;
        run(-1, dur);
        checks++;
        if (dur !== 3 + 6 * 255) begin
            errors++;
            $display("FAIL len255_cycles: got %0d required %0d", dur, 3 + 6 * 255);
        end
        checks++;
        if (pt_wr_cnt - w0 !== 256) begin
            errors++;
            $display("FAIL len255_writes: got %0d required 256", pt_wr_cnt - w0);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (pt_mem[n] !== gpt[n]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL len255_pt: %0d bytes differ from model, required 0", bad);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== gs[n]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL len255_s: %0d S entries differ from model, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int sw, pw, dur;
        load_identity();
        ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        sw = s_wr_cnt;
        pw = pt_wr_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rdy_low: got %b required 0", rdy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rdy_release: got %b required 1", rdy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (s_wr_cnt != sw || pt_wr_cnt != pw) begin
            errors++;
            $display("FAIL midreset_writes: s=%0d pt=%0d new writes, required 0 0", s_wr_cnt - sw, pt_wr_cnt - pw);
        end
        checks++;
        if (pt_mem[2] !== 8'hEE) begin
            errors++;
            $display("FAIL midreset_pt2: got %h required EE", pt_mem[2]);
        end
        load_identity();
        run(-1, dur);
        checks++;
        if ({pt_mem[1], pt_mem[2], pt_mem[3]} !== 24'h434744 || dur !== 21) begin
            errors++;
            $display("FAIL midreset_rerun: pt=%h cycles=%0d required 434744 21", {pt_mem[1], pt_mem[2], pt_mem[3]}, dur);
        end
    endtask

    task automatic test_back_to_back();
        int t0, d1, d2, w0;
        d1 = -1;
        d2 = -1;
        load_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h41;
        w0 = pt_wr_cnt;
        en = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (rdy) begin d1 = cyc - t0; break; end
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: rdy=%b after held en, required 0", rdy);
        end
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (rdy) begin d2 = cyc - t0; en = 1'b0; break; end
        end
        en = 1'b0;
        checks++;
        if (d1 !== 9 || d2 !== 9) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d %0d required 9 9", d1, d2);
        end
        checks++;
        if (pt_wr_cnt - w0 !== 4 || pt_mem[1] !== 8'h43) begin
            errors++;
            $display("FAIL b2b_pt: writes=%0d pt1=%h required 4 43", pt_wr_cnt - w0, pt_mem[1]);
        end
    endtask

    task automatic test_rc4_vector();
        int dur, bad, j;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) gs[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(gs[n])) % 256;
            t = gs[n]; gs[n] = gs[j]; gs[j] = t;
        end
        for (int n = 0; n < 256; n++) begin
            s_mem[n] = gs[n];
            pt_mem[n] = 8'hEE;
        end
        ct_mem[0] = 8'd16;
        gct[0] = 8'd16;
        for (int n = 1; n <= 16; n++) begin
            ct_mem[n] = 8'(n * 29 + 7);
            gct[n] = ct_mem[n];
        end
        model_prga(16);
        run(-1, dur);
        bad = 0;
        for (int n = 0; n <= 16; n++) if (pt_mem[n] !== gpt[n]) bad++;
        checks++;
        if (bad != 0 || dur !== 99) begin
            errors++;
            $display("FAIL rc4_vector: %0d bytes differ, cycles=%0d, required 0 and 99", bad, dur);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_len0();
        test_len255();
        test_reset_mid();
        test_back_to_back();
        test_rc4_vector();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL wren_exclusive: %0d cycles with both enables, required 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
